// File: rtl/led_state_sequencer_if.sv
// Bundle between the LED sequencer (master) and the pattern-state modules (slave).
// The master drives begin lines and the LED bus. The slave returns done flags and patterns.
interface led_state_sequencer_if #(
  parameter int NUM_STATES = 4,
  parameter int WIDTH      = 18
);
  localparam int IDXW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;

  logic                        enabler;
  logic [NUM_STATES-1:0]       stMask;
  logic [NUM_STATES-1:0]       stOver;
  logic [NUM_STATES*WIDTH-1:0] patIn;
  logic [NUM_STATES-1:0]       stBegin;
  logic [WIDTH-1:0]            out;
  logic [IDXW-1:0]             curIdx;
  logic                        cycleDone;
  logic                        fault;
  logic [IDXW-1:0]             faultIdx;

  modport master (
    input  enabler, stMask, stOver, patIn,
    output stBegin, out, curIdx, cycleDone, fault, faultIdx
  );

  modport slave (
    output enabler, stMask, stOver, patIn,
    input  stBegin, out, curIdx, cycleDone, fault, faultIdx
  );
endinterface

// File: rtl/led_state_sequencer.sv
// Runs the enabled LED pattern states in order, with a blank gap between them.
// It muxes the active pattern onto the LED bus and latches a watchdog fault for any state that hangs.
//
// state  | meaning
// IDLE   | disabled or empty mask; begin lines and LED bus low
// SELECT | one cycle; pick the next enabled state at or after ptr, else wrap
// RUN    | begin line of idx held high until done or watchdog expiry
// GAP    | blank LED bus for GAP_CYCLES cycles before the next SELECT
module led_state_sequencer #(
  parameter int NUM_STATES = 4,
  parameter int WIDTH      = 18,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  localReset,
  led_state_sequencer_if.master bus
);
  localparam int IDXW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam int PTRW = IDXW + 1;
  localparam int WW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NUM_STATES-1:0] ONE = NUM_STATES'(1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_RUN, S_GAP} state_t;

  state_t                state, state_d;
  logic [PTRW-1:0]       ptr, ptr_d;
  logic [IDXW-1:0]       idx, idx_d;
  logic [GW-1:0]         gap_cnt, gap_d;
  logic [WW-1:0]         wd_cnt, wd_d;
  logic                  fault, fault_d;
  logic [IDXW-1:0]       fault_idx, fault_idx_d;
  logic [NUM_STATES-1:0] st_begin, st_begin_d;

  logic                  any_en, found_ge, timed_out;
  logic [IDXW-1:0]       sel_ge, sel_any;

  // ptr may equal NUM_STATES after the last state, and that case falls through to the wrap choice.
  always_comb begin
    any_en   = 1'b0;
    found_ge = 1'b0;
    sel_ge   = '0;
    sel_any  = '0;
    for (int i = NUM_STATES - 1; i >= 0; i--) begin
      if (bus.stMask[i]) begin
        any_en  = 1'b1;
        sel_any = IDXW'(i);
        if (PTRW'(i) >= ptr) begin
          found_ge = 1'b1;
          sel_ge   = IDXW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    idx_d       = idx;
    gap_d       = gap_cnt;
    wd_d        = wd_cnt;
    fault_d     = fault;
    fault_idx_d = fault_idx;
    st_begin_d  = '0;
    timed_out   = 1'b0;
    if (state != S_IDLE && !bus.enabler) begin
      state_d = S_IDLE;
      ptr_d   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.enabler && any_en) begin
            state_d = S_SELECT;
            ptr_d   = '0;
          end
        end
        S_SELECT: begin
          if (!any_en) begin
            state_d = S_IDLE;
            ptr_d   = '0;
          end else begin
            idx_d      = found_ge ? sel_ge : sel_any;
            wd_d       = '0;
            state_d    = S_RUN;
            st_begin_d = ONE << idx_d;
          end
        end
        S_RUN: begin
          st_begin_d = st_begin;
          if (wd_cnt != {WW{1'b1}}) wd_d = wd_cnt + WW'(1);
          timed_out = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
          // A done flag on the expiry cycle still counts as a clean finish.
          if (bus.stOver[idx] || timed_out) begin
            if (!bus.stOver[idx]) begin
              fault_d     = 1'b1;
              fault_idx_d = idx;
            end
            st_begin_d = '0;
            ptr_d      = PTRW'(idx) + PTRW'(1);
            gap_d      = '0;
            state_d    = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state_d = S_SELECT;
          else                     gap_d   = gap_cnt + GW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge localReset) begin
    if (localReset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      wd_cnt    <= '0;
      fault     <= 1'b0;
      fault_idx <= '0;
      st_begin  <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      idx       <= idx_d;
      gap_cnt   <= gap_d;
      wd_cnt    <= wd_d;
      fault     <= fault_d;
      fault_idx <= fault_idx_d;
      st_begin  <= st_begin_d;
    end
  end

  assign bus.stBegin   = st_begin;
  assign bus.out       = (state == S_RUN) ? bus.patIn[int'(idx) * WIDTH +: WIDTH] : '0;
  assign bus.curIdx    = idx;
  assign bus.cycleDone = (state == S_SELECT) && any_en && !found_ge;
  assign bus.fault     = fault;
  assign bus.faultIdx  = fault_idx;
endmodule

// File: tb/tb_led_state_sequencer.sv
// Scoreboard bench for led_state_sequencer: expected runs are queued per scenario.
// A negedge monitor logs each observed begin-line run, and the scenario tasks compare the two.
module tb_led_state_sequencer;
  localparam int NS = 4, W = 18, GAP = 2, TO = 8;

  logic clk = 1'b0;
  logic localReset = 1'b1;
  always #5 clk = ~clk;

  led_state_sequencer_if #(.NUM_STATES(NS), .WIDTH(W)) bus();
  led_state_sequencer #(.NUM_STATES(NS), .WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .localReset(localReset), .bus(bus)
  );

  // State-module model: done 5 cycles after begin unless hung
  logic [NS-1:0] hang;
  logic [NS-1:0] ov;
  int unsigned mcnt [NS];
  always @(posedge clk or posedge localReset)
    for (int i = 0; i < NS; i++) mcnt[i] <= localReset ? 0 : (bus.stBegin[i] ? mcnt[i] + 1 : 0);
  always_comb begin
    ov = '0;
    for (int i = 0; i < NS; i++) ov[i] = bus.stBegin[i] && (mcnt[i] == 4) && !hang[i];
  end
  assign bus.stOver = ov;

  typedef struct { logic [NS-1:0] bgn; logic [1:0] idx; logic [W-1:0] outv; int len; int blank; logic cd; logic bad_out; } rec_t;
  typedef struct { logic [NS-1:0] bgn; logic [1:0] idx; int len; int blank; logic cd; } exp_t;
  rec_t obs[$];
  exp_t expq[$];
  rec_t cur;
  logic [NS-1:0] prev_b;
  int blank_n;
  logic cd_seen, bad_seen;

  always @(negedge clk) begin
    if (localReset) begin
      prev_b = '0; blank_n = 0; cd_seen = 1'b0; bad_seen = 1'b0;
    end else begin
      if (bus.cycleDone) cd_seen = 1'b1;
      if (bus.stBegin == '0) begin
        if (bus.out !== '0) bad_seen = 1'b1;
        if (prev_b != '0) begin
          cur.bad_out = bad_seen;
          obs.push_back(cur);
          blank_n = 0; bad_seen = 1'b0;
        end
        blank_n++;
      end else if (prev_b == '0) begin
        cur.bgn = bus.stBegin; cur.idx = bus.curIdx; cur.outv = bus.out;
        cur.len = 1; cur.blank = blank_n; cur.cd = cd_seen; cd_seen = 1'b0;
      end else begin
        cur.len++;
        if (bus.out !== cur.outv) bad_seen = 1'b1;
      end
      prev_b = bus.stBegin;
    end
  end

  logic [W-1:0] pat [NS];
  int checks = 0, failures = 0, rd = 0;
  exp_t e;
  rec_t o;

  task automatic expect_run(input logic [NS-1:0] b, input logic [1:0] i, input int len, input int blank, input logic cd);
    exp_t x;
    x.bgn = b; x.idx = i; x.len = len; x.blank = blank; x.cd = cd;
    expq.push_back(x);
  endtask

  task automatic restart(input logic [NS-1:0] mask, input logic [NS-1:0] hg);
    @(negedge clk); #1;
    localReset = 1'b1; bus.enabler = 1'b0; bus.stMask = mask; hang = hg;
    @(negedge clk); @(negedge clk); #1;
    localReset = 1'b0;
    rd = obs.size();
    @(negedge clk);
    bus.enabler = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (bus.stBegin !== '0) begin failures++; $display("FAIL reset_stBegin got=%b want=0", bus.stBegin); end
    checks++; if (bus.out !== '0) begin failures++; $display("FAIL reset_out got=%h want=0", bus.out); end
    checks++; if (bus.curIdx !== '0) begin failures++; $display("FAIL reset_curIdx got=%0d want=0", bus.curIdx); end
    checks++; if (bus.cycleDone !== 1'b0) begin failures++; $display("FAIL reset_cycleDone got=%b want=0", bus.cycleDone); end
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b want=0", bus.fault); end
    checks++; if (bus.faultIdx !== '0) begin failures++; $display("FAIL reset_faultIdx got=%0d want=0", bus.faultIdx); end
    @(negedge clk); #1 localReset = 1'b0;
    bus.enabler = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.stBegin !== '0 || bus.cycleDone !== 1'b0) begin
      failures++; $display("FAIL empty_mask_idle stBegin=%b cycleDone=%b want 0/0", bus.stBegin, bus.cycleDone); end
    bus.enabler = 1'b0; bus.stMask = 4'b1111;
    repeat (3) @(negedge clk);
    checks++; if (bus.stBegin !== '0 || bus.out !== '0) begin
      failures++; $display("FAIL disabled_idle stBegin=%b out=%h want 0/0", bus.stBegin, bus.out); end
  endtask

  task automatic test_full_mask;
    restart(4'b1111, 4'b0000);
    expect_run(4'b0001, 2'd0, 5, 0, 1'b0);
    expect_run(4'b0010, 2'd1, 5, 3, 1'b0);
    expect_run(4'b0100, 2'd2, 5, 3, 1'b0);
    expect_run(4'b1000, 2'd3, 5, 3, 1'b0);
    expect_run(4'b0001, 2'd0, 5, 3, 1'b1);
    repeat (45) @(negedge clk);
    while (expq.size() > 0) begin
      e = expq.pop_front(); checks++;
      if (rd >= obs.size()) begin failures++; $display("FAIL full_mask_run got=none want begin=%b", e.bgn); end
      else begin
        o = obs[rd]; rd++;
        if (o.bgn !== e.bgn || o.idx !== e.idx || o.outv !== pat[e.idx] || o.len != e.len || o.cd !== e.cd || o.bad_out
            || (e.blank != 0 && o.blank != e.blank)) begin
          failures++;
          $display("FAIL full_mask_run got begin=%b idx=%0d out=%h len=%0d blank=%0d cd=%b badout=%b want begin=%b idx=%0d out=%h len=%0d blank=%0d cd=%b",
                   o.bgn, o.idx, o.outv, o.len, o.blank, o.cd, o.bad_out, e.bgn, e.idx, pat[e.idx], e.len, e.blank, e.cd);
        end
      end
    end
  endtask

  task automatic test_sparse_mask;
    restart(4'b1010, 4'b0000);
    expect_run(4'b0010, 2'd1, 5, 0, 1'b0);
    expect_run(4'b1000, 2'd3, 5, 3, 1'b0);
    expect_run(4'b0010, 2'd1, 5, 3, 1'b1);
    expect_run(4'b1000, 2'd3, 5, 3, 1'b0);
    expect_run(4'b0010, 2'd1, 5, 3, 1'b1);
    repeat (45) @(negedge clk);
    while (expq.size() > 0) begin
      e = expq.pop_front(); checks++;
      if (rd >= obs.size()) begin failures++; $display("FAIL sparse_run got=none want begin=%b", e.bgn); end
      else begin
        o = obs[rd]; rd++;
        if (o.bgn !== e.bgn || o.idx !== e.idx || o.outv !== pat[e.idx] || o.len != e.len || o.cd !== e.cd || o.bad_out
            || (e.blank != 0 && o.blank != e.blank)) begin
          failures++;
          $display("FAIL sparse_run got begin=%b idx=%0d out=%h len=%0d blank=%0d cd=%b badout=%b want begin=%b idx=%0d out=%h len=%0d blank=%0d cd=%b",
                   o.bgn, o.idx, o.outv, o.len, o.blank, o.cd, o.bad_out, e.bgn, e.idx, pat[e.idx], e.len, e.blank, e.cd);
        end
      end
    end
  endtask

  task automatic test_timeout;
    restart(4'b1111, 4'b0100);
    expect_run(4'b0001, 2'd0, 5, 0, 1'b0);
    expect_run(4'b0010, 2'd1, 5, 3, 1'b0);
    expect_run(4'b0100, 2'd2, TO, 3, 1'b0);
    expect_run(4'b1000, 2'd3, 5, 3, 1'b0);
    expect_run(4'b0001, 2'd0, 5, 3, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL timeout_early_fault got=%b want=0", bus.fault); end
    repeat (38) @(negedge clk);
    checks++; if (bus.fault !== 1'b1 || bus.faultIdx !== 2'd2) begin
      failures++; $display("FAIL timeout_fault got fault=%b idx=%0d want 1/2", bus.fault, bus.faultIdx); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); checks++;
      if (rd >= obs.size()) begin failures++; $display("FAIL timeout_run got=none want begin=%b", e.bgn); end
      else begin
        o = obs[rd]; rd++;
        if (o.bgn !== e.bgn || o.idx !== e.idx || o.outv !== pat[e.idx] || o.len != e.len || o.cd !== e.cd || o.bad_out
            || (e.blank != 0 && o.blank != e.blank)) begin
          failures++;
          $display("FAIL timeout_run got begin=%b idx=%0d out=%h len=%0d blank=%0d cd=%b badout=%b want begin=%b idx=%0d out=%h len=%0d blank=%0d cd=%b",
                   o.bgn, o.idx, o.outv, o.len, o.blank, o.cd, o.bad_out, e.bgn, e.idx, pat[e.idx], e.len, e.blank, e.cd);
        end
      end
    end
  endtask

  task automatic test_abort;
    restart(4'b1111, 4'b0000);
    for (int k = 0; k < 60 && bus.stBegin !== 4'b0100; k++) @(negedge clk);
    checks++; if (bus.stBegin !== 4'b0100) begin failures++; $display("FAIL abort_wait got=%b want=0100", bus.stBegin); end
    bus.enabler = 1'b0;
    @(negedge clk);
    checks++; if (bus.stBegin !== '0 || bus.out !== '0) begin
      failures++; $display("FAIL abort_idle got stBegin=%b out=%h want 0/0", bus.stBegin, bus.out); end
    repeat (2) @(negedge clk);
    bus.enabler = 1'b1;
    @(negedge clk);
    checks++; if (bus.stBegin !== '0 || bus.cycleDone !== 1'b0) begin
      failures++; $display("FAIL reenable_select got stBegin=%b cycleDone=%b want 0/0", bus.stBegin, bus.cycleDone); end
    @(negedge clk);
    checks++; if (bus.stBegin !== 4'b0001 || bus.curIdx !== 2'd0 || bus.out !== pat[0]) begin
      failures++; $display("FAIL reenable_run got stBegin=%b idx=%0d out=%h want 0001/0/%h", bus.stBegin, bus.curIdx, bus.out, pat[0]); end
  endtask

  task automatic test_mask_off;
    logic cd_any;
    cd_any = 1'b0;
    restart(4'b1111, 4'b0000);
    expect_run(4'b0001, 2'd0, 5, 0, 1'b0);
    expect_run(4'b0010, 2'd1, 5, 3, 1'b0);
    for (int k = 0; k < 40 && bus.stBegin !== 4'b0010; k++) @(negedge clk);
    bus.stMask = 4'b0000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cd_any |= bus.cycleDone;
    end
    while (expq.size() > 0) begin
      e = expq.pop_front(); checks++;
      if (rd >= obs.size()) begin failures++; $display("FAIL mask_off_run got=none want begin=%b", e.bgn); end
      else begin
        o = obs[rd]; rd++;
        if (o.bgn !== e.bgn || o.idx !== e.idx || o.outv !== pat[e.idx] || o.len != e.len || o.cd !== e.cd || o.bad_out
            || (e.blank != 0 && o.blank != e.blank)) begin
          failures++;
          $display("FAIL mask_off_run got begin=%b idx=%0d out=%h len=%0d blank=%0d cd=%b badout=%b want begin=%b idx=%0d out=%h len=%0d blank=%0d cd=%b",
                   o.bgn, o.idx, o.outv, o.len, o.blank, o.cd, o.bad_out, e.bgn, e.idx, pat[e.idx], e.len, e.blank, e.cd);
        end
      end
    end
    checks++; if (obs.size() != rd) begin failures++; $display("FAIL mask_off_extra got=%0d extra runs want=0", obs.size() - rd); end
    checks++; if (bus.stBegin !== '0 || bus.out !== '0 || cd_any !== 1'b0) begin
      failures++; $display("FAIL mask_off_idle got stBegin=%b out=%h cd=%b want 0/0/0", bus.stBegin, bus.out, cd_any); end
  endtask

  task automatic test_async_reset;
    restart(4'b1111, 4'b0001);
    for (int k = 0; k < 80 && bus.stBegin !== 4'b0100; k++) @(negedge clk);
    checks++; if (bus.stBegin !== 4'b0100 || bus.fault !== 1'b1 || bus.curIdx !== 2'd2) begin
      failures++; $display("FAIL pre_reset got stBegin=%b fault=%b idx=%0d want 0100/1/2", bus.stBegin, bus.fault, bus.curIdx); end
    #2 localReset = 1'b1;
    #1;
    checks++; if (bus.stBegin !== '0 || bus.out !== '0 || bus.cycleDone !== 1'b0) begin
      failures++; $display("FAIL async_reset_out got stBegin=%b out=%h cd=%b want 0/0/0", bus.stBegin, bus.out, bus.cycleDone); end
    checks++; if (bus.fault !== 1'b0 || bus.curIdx !== '0 || bus.faultIdx !== '0) begin
      failures++; $display("FAIL async_reset_regs got fault=%b idx=%0d fidx=%0d want 0/0/0", bus.fault, bus.curIdx, bus.faultIdx); end
    @(negedge clk); #1 localReset = 1'b0;
  endtask

  initial begin
    bus.enabler = 1'b0;
    bus.stMask  = '0;
    hang        = '0;
    for (int i = 0; i < NS; i++) pat[i] = W'($urandom) | W'(1 << i);
    bus.patIn = {pat[3], pat[2], pat[1], pat[0]};
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_timeout();
    test_abort();
    test_mask_off();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
